dispatch_queue: RTL and testbench

Multi-port in-order buffer between rename and dispatch. Each cycle it accepts up to INPORTS valid instructions from a sparse valid mask, packs them contiguously at the tail, and presents up to OUTPORTS oldest entries at the head. The downstream consumer retires the longest contiguous accepted prefix. Valid-mask arithmetic uses the shared `funcs` helpers `count_one` and `continuous_one`.

---
 rtl/dispatch_queue_pkg.sv | 23 ++
 rtl/funcs.sv | 26 ++
 rtl/dispatch_queue_if.sv | 31 +++
 rtl/dispatch_queue_enq_compact.sv | 31 +++
 rtl/dispatch_queue.sv | 121 ++++++++++++
 tb/tb_dispatch_queue.sv | 235 +++++++++++++++++++++++
 6 files changed

// File: rtl/dispatch_queue_pkg.sv
// Default geometry, derived pointer/count widths and payload type for the
// dispatch queue.
package dispatch_queue_pkg;

    localparam int unsigned DQ_DEPTH      = 16;
    localparam int unsigned DQ_INPORTS    = 4;
    localparam int unsigned DQ_OUTPORTS   = 4;
    localparam int unsigned DQ_DATA_WIDTH = 64;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return ptr_width(depth) + 1;
    endfunction

    localparam int unsigned DQ_PTR_W = ptr_width(DQ_DEPTH);
    localparam int unsigned DQ_CNT_W = cnt_width(DQ_DEPTH);

    typedef logic [DQ_DATA_WIDTH-1:0] dq_entry_t;

endpackage

// File: rtl/funcs.sv
// Shared valid-mask helpers: population count and length of the contiguous
// run of ones starting at bit 0. Masks are zero-extended to 32 bits by callers.
package funcs;

    function automatic logic [5:0] count_one(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'b0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [5:0] continuous_one(input logic [31:0] v);
        logic [5:0] n;
        logic       run;
        n   = '0;
        run = 1'b1;
        for (int i = 0; i < 32; i++) begin
            run = run & v[i];
            n   = n + {5'b0, run};
        end
        return n;
    endfunction

endpackage

// File: rtl/dispatch_queue_if.sv
// Enqueue/dequeue bundle of the dispatch queue. master = producer/consumer side,
// slave = the queue itself.
interface dispatch_queue_if
    import dispatch_queue_pkg::*;
#(
    parameter int unsigned DEPTH      = DQ_DEPTH,
    parameter int unsigned INPORTS    = DQ_INPORTS,
    parameter int unsigned OUTPORTS   = DQ_OUTPORTS,
    parameter int unsigned DATA_WIDTH = DQ_DATA_WIDTH
);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic [INPORTS-1:0]                  i_enq_vld;
    logic [INPORTS-1:0][DATA_WIDTH-1:0]  i_enq_data;
    logic                                o_can_enq;
    logic [OUTPORTS-1:0]                 o_deq_vld;
    logic [OUTPORTS-1:0][DATA_WIDTH-1:0] o_deq_data;
    logic [OUTPORTS-1:0]                 i_deq_rdy;
    logic [CNT_W-1:0]                    o_count;

    modport master (
        output i_enq_vld, i_enq_data, i_deq_rdy,
        input  o_can_enq, o_deq_vld, o_deq_data, o_count
    );

    modport slave (
        input  i_enq_vld, i_enq_data, i_deq_rdy,
        output o_can_enq, o_deq_vld, o_deq_data, o_count
    );

endinterface

// File: rtl/dispatch_queue_enq_compact.sv
// Maps a sparse enqueue mask onto contiguous slot offsets from the tail:
// each lane's offset is the number of set lanes below it.
module enq_compact
    import funcs::*;
#(
    parameter int unsigned INPORTS = 4,
    parameter int unsigned OFF_W   = 4
) (
    input  logic [INPORTS-1:0]            vld,
    input  logic                          en,
    output logic [INPORTS-1:0]            we,
    output logic [INPORTS-1:0][OFF_W-1:0] offset,
    output logic [5:0]                    nenq
);

    logic [31:0]      vld_ext;
    logic [OFF_W-1:0] run;

    always_comb begin
        vld_ext              = '0;
        vld_ext[INPORTS-1:0] = vld;
        run                  = '0;
        for (int i = 0; i < INPORTS; i++) begin
            offset[i] = run;
            we[i]     = en & vld[i];
            run       = run + OFF_W'(vld[i]);
        end
        nenq = count_one(vld_ext);
    end

endmodule

// File: rtl/dispatch_queue.sv
// In-order multi-port dispatch queue: packs sparse enqueue groups at the tail and
// retires the contiguous accepted prefix at the head. Define DISPATCH_QUEUE_PERF_EN
// to add the saturating o_stall_cycles counter.
module dispatch_queue
    import dispatch_queue_pkg::*;
    import funcs::*;
#(
    parameter int unsigned DEPTH      = DQ_DEPTH,
    parameter int unsigned INPORTS    = DQ_INPORTS,
    parameter int unsigned OUTPORTS   = DQ_OUTPORTS,
    parameter int unsigned DATA_WIDTH = DQ_DATA_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_flush,
    dispatch_queue_if.slave dq
`ifdef DISPATCH_QUEUE_PERF_EN
    ,
    output logic [31:0]     o_stall_cycles
`endif
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                            can_enq;
    logic                            fire;
    logic [INPORTS-1:0]              we;
    logic [INPORTS-1:0][PTR_W-1:0]   offset;
    logic [5:0]                      nenq;
    logic [5:0]                      ndeq;
    logic [OUTPORTS-1:0]             deq_vld;
    logic [31:0]                     accept_ext;

    // Space check uses the pre-dequeue count so freed slots wait a cycle.
    assign can_enq = (CNT_W'(DEPTH) - count_q) >= CNT_W'(INPORTS);
    assign fire    = can_enq & (|dq.i_enq_vld);

    enq_compact #(
        .INPORTS (INPORTS),
        .OFF_W   (PTR_W)
    ) u_enq_compact (
        .vld    (dq.i_enq_vld),
        .en     (fire),
        .we     (we),
        .offset (offset),
        .nenq   (nenq)
    );

    always_comb begin
        for (int i = 0; i < OUTPORTS; i++) begin
            deq_vld[i]       = count_q > CNT_W'(i);
            dq.o_deq_data[i] = mem_q[head_q + PTR_W'(i)];
        end
        accept_ext               = '0;
        accept_ext[OUTPORTS-1:0] = dq.i_deq_rdy & deq_vld;
        ndeq                     = continuous_one(accept_ext);
    end

    always_comb begin
        head_d  = PTR_W'(32'(head_q) + 32'(ndeq));
        tail_d  = tail_q;
        count_d = CNT_W'(32'(count_q) - 32'(ndeq));
        if (fire) begin
            tail_d  = PTR_W'(32'(tail_q) + 32'(nenq));
            count_d = CNT_W'(32'(count_q) - 32'(ndeq) + 32'(nenq));
        end
        if (i_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!rst && !i_flush) begin
            for (int i = 0; i < INPORTS; i++) begin
                if (we[i]) begin
                    mem_q[tail_q + offset[i]] <= dq.i_enq_data[i];
                end
            end
        end
    end

    assign dq.o_can_enq = can_enq;
    assign dq.o_deq_vld = deq_vld;
    assign dq.o_count   = count_q;

`ifdef DISPATCH_QUEUE_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if ((|dq.i_enq_vld) && !can_enq && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign o_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_dispatch_queue.sv
// Self-checking bench for dispatch_queue: queue-based reference model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_dispatch_queue;
    import dispatch_queue_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned INP   = 4;
    localparam int unsigned OUTP  = 4;
    localparam int unsigned DW    = 64;

    localparam logic [63:0] DA = 64'hAAAA_0000_0000_000A;
    localparam logic [63:0] DB = 64'hBBBB_0000_0000_000B;
    localparam logic [63:0] DJ = 64'hDEAD_DEAD_DEAD_DEAD;

    logic clk;
    logic rst;
    logic i_flush;

    dispatch_queue_if #(
        .DEPTH(DEPTH), .INPORTS(INP), .OUTPORTS(OUTP), .DATA_WIDTH(DW)
    ) dq_if ();

`ifdef DISPATCH_QUEUE_PERF_EN
    logic [31:0] stall_cycles;
`endif

    dispatch_queue #(
        .DEPTH(DEPTH), .INPORTS(INP), .OUTPORTS(OUTP), .DATA_WIDTH(DW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_flush (i_flush),
        .dq      (dq_if)
`ifdef DISPATCH_QUEUE_PERF_EN
        ,
        .o_stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue contents in age order plus the stall count.
    dq_entry_t   mq[$];
    int unsigned m_stall = 0;

    always @(posedge clk) begin
        int sz;
        int n;
        bit can;
        sz  = mq.size();
        can = (DEPTH - sz) >= INP;
        n   = 0;
        if ((|dq_if.i_enq_vld) && !can && (m_stall != 32'hFFFF_FFFF)) m_stall++;
        if (rst) begin
            mq.delete();
            m_stall = 0;
        end else if (i_flush) begin
            mq.delete();
        end else begin
            while (n < OUTP && n < sz && dq_if.i_deq_rdy[n]) n++;
            repeat (n) void'(mq.pop_front());
            if (can) begin
                for (int k = 0; k < INP; k++) begin
                    if (dq_if.i_enq_vld[k]) mq.push_back(dq_if.i_enq_data[k]);
                end
            end
        end
    end

    logic [OUTP-1:0] ev;

    always @(negedge clk) begin
        if (chk_en) begin
            ev = '0;
            for (int i = 0; i < OUTP; i++) if (i < mq.size()) ev[i] = 1'b1;
            check("can_enq", 64'(dq_if.o_can_enq), 64'((DEPTH - mq.size()) >= INP));
            check("deq_vld", 64'(dq_if.o_deq_vld), 64'(ev));
            check("count", 64'(dq_if.o_count), 64'(mq.size()));
            for (int i = 0; i < OUTP; i++) begin
                if (i < mq.size()) check($sformatf("deq_data%0d", i), dq_if.o_deq_data[i], mq[i]);
            end
`ifdef DISPATCH_QUEUE_PERF_EN
            check("stall_cycles", 64'(stall_cycles), 64'(m_stall));
`endif
        end
    end

    function automatic logic [3:0][63:0] grp(input logic [63:0] base);
        logic [3:0][63:0] r;
        for (int k = 0; k < 4; k++) r[k] = base + 64'(k);
        return r;
    endfunction

    task automatic step(input logic [3:0] vld, input logic [3:0][63:0] d,
                        input logic [3:0] rdy, input bit fl);
        dq_if.i_enq_vld = vld;
        dq_if.i_deq_rdy = rdy;
        i_flush         = fl;
        for (int k = 0; k < INP; k++) dq_if.i_enq_data[k] = d[k];
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [63:0] dut_v, input logic [63:0] mdl_v,
                       input logic [63:0] exp);
        check({name, "_dut"}, dut_v, exp);
        check({name, "_model"}, mdl_v, exp);
    endtask

    initial begin
        rst             = 1'b1;
        i_flush         = 1'b0;
        dq_if.i_enq_vld = '0;
        dq_if.i_deq_rdy = '0;
        dq_if.i_enq_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        rst    = 1'b0;

        // Reset state, then idle
        lit("rst_count", 64'(dq_if.o_count), 64'(mq.size()), 64'd0);
        check("rst_can_enq", 64'(dq_if.o_can_enq), 64'd1);
        check("rst_deq_vld", 64'(dq_if.o_deq_vld), 64'd0);
        step(4'b0000, grp(0), 4'b0000, 1'b0);
        lit("idle_count", 64'(dq_if.o_count), 64'(mq.size()), 64'd0);

        // Sparse enqueue packs lanes 1,3 into head lanes 0,1
        step(4'b1010, {DB, DJ, DA, DJ}, 4'b0000, 1'b0);
        lit("sparse_count", 64'(dq_if.o_count), 64'(mq.size()), 64'd2);
        check("sparse_vld", 64'(dq_if.o_deq_vld), 64'h3);
        lit("sparse_lane0", dq_if.o_deq_data[0], mq[0], DA);
        lit("sparse_lane1", dq_if.o_deq_data[1], mq[1], DB);
        step(4'b0000, grp(0), 4'b0000, 1'b1);

        // Fill with four full groups; full queue blocks further groups
        for (int g = 0; g < 4; g++) step(4'b1111, grp(64'h100 + 64'(4 * g)), 4'b0000, 1'b0);
        lit("full_count", 64'(dq_if.o_count), 64'(mq.size()), 64'd16);
        check("full_can_enq", 64'(dq_if.o_can_enq), 64'd0);
        repeat (3) step(4'b0001, grp(64'h900), 4'b0000, 1'b0);
        lit("blocked_count", 64'(dq_if.o_count), 64'(mq.size()), 64'd16);
        lit("full_lane0", dq_if.o_deq_data[0], mq[0], 64'h100);
`ifdef DISPATCH_QUEUE_PERF_EN
        lit("stall3", 64'(stall_cycles), 64'(m_stall), 64'd3);
`endif

        // Boundary: 13 entries deasserts can_enq
        step(4'b0000, grp(0), 4'b0000, 1'b1);
        for (int g = 0; g < 3; g++) step(4'b1111, grp(64'h200 + 64'(4 * g)), 4'b0000, 1'b0);
        check("cnt12_can_enq", 64'(dq_if.o_can_enq), 64'd1);
        step(4'b0001, grp(64'h20C), 4'b0000, 1'b0);
        lit("cnt13_count", 64'(dq_if.o_count), 64'(mq.size()), 64'd13);
        check("cnt13_can_enq", 64'(dq_if.o_can_enq), 64'd0);
        step(4'b0001, grp(64'h990), 4'b0000, 1'b0);
        lit("cnt13_blocked", 64'(dq_if.o_count), 64'(mq.size()), 64'd13);
        step(4'b0000, grp(0), 4'b1111, 1'b0);
        lit("drain4_count", 64'(dq_if.o_count), 64'(mq.size()), 64'd9);
        lit("drain4_lane0", dq_if.o_deq_data[0], mq[0], 64'h204);

        // rdy gap stops retirement after lane 0
        step(4'b0000, grp(0), 4'b0000, 1'b1);
        step(4'b1111, grp(64'h300), 4'b0000, 1'b0);
        step(4'b0000, grp(0), 4'b1101, 1'b0);
        lit("gap_count", 64'(dq_if.o_count), 64'(mq.size()), 64'd3);
        lit("gap_lane0", dq_if.o_deq_data[0], mq[0], 64'h301);

        // Simultaneous enqueue and dequeue
        step(4'b1111, grp(64'h400), 4'b1111, 1'b0);
        lit("simul_count", 64'(dq_if.o_count), 64'(mq.size()), 64'd4);
        lit("simul_lane0", dq_if.o_deq_data[0], mq[0], 64'h400);

        // Empty queue ignores rdy
        step(4'b0000, grp(0), 4'b0000, 1'b1);
        step(4'b0000, grp(0), 4'b1111, 1'b0);
        lit("empty_rdy_count", 64'(dq_if.o_count), 64'(mq.size()), 64'd0);

        // Move head and tail to 14, then enqueue a group straddling the wrap
        for (int g = 0; g < 3; g++) step(4'b1111, grp(64'h500), 4'b0000, 1'b0);
        step(4'b0011, grp(64'h500), 4'b0000, 1'b0);
        repeat (4) step(4'b0000, grp(0), 4'b1111, 1'b0);
        lit("pre_wrap_count", 64'(dq_if.o_count), 64'(mq.size()), 64'd0);
        step(4'b1111, grp(64'h600), 4'b0000, 1'b0);
        lit("wrap_count", 64'(dq_if.o_count), 64'(mq.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            lit($sformatf("wrap_lane%0d", i), dq_if.o_deq_data[i], mq[i], 64'h600 + 64'(i));
        end
        step(4'b0000, grp(0), 4'b0001, 1'b0);
        lit("wrap_pop1_lane0", dq_if.o_deq_data[0], mq[0], 64'h601);
        step(4'b0000, grp(0), 4'b0111, 1'b0);
        lit("wrap_drained", 64'(dq_if.o_count), 64'(mq.size()), 64'd0);

        // Flush beats a same-cycle enqueue; next group starts fresh
        step(4'b1111, grp(64'h700), 4'b0000, 1'b0);
        step(4'b1111, grp(64'h710), 4'b1111, 1'b1);
        lit("flush_count", 64'(dq_if.o_count), 64'(mq.size()), 64'd0);
        check("flush_vld", 64'(dq_if.o_deq_vld), 64'd0);
        step(4'b1111, grp(64'h720), 4'b0000, 1'b0);
        lit("post_flush_lane0", dq_if.o_deq_data[0], mq[0], 64'h720);
        lit("post_flush_count", 64'(dq_if.o_count), 64'(mq.size()), 64'd4);

        // Mid-operation reset
        rst = 1'b1;
        step(4'b0000, grp(0), 4'b0000, 1'b0);
        rst = 1'b0;
        lit("midrst_count", 64'(dq_if.o_count), 64'(mq.size()), 64'd0);
`ifdef DISPATCH_QUEUE_PERF_EN
        lit("midrst_stall", 64'(stall_cycles), 64'(m_stall), 64'd0);
`endif

        // Mixed traffic, checked against the model every cycle
        for (int c = 0; c < 80; c++) begin
            logic [3:0][63:0] d;
            for (int k = 0; k < 4; k++) d[k] = {$urandom, $urandom};
            step(4'($urandom), d, 4'($urandom), ($urandom_range(0, 15) == 0));
        end
        step(4'b0000, grp(0), 4'b0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
